// File: rtl/sdiv_iter.sv
// sdiv_iter -- iterative signed divider (restoring, one quotient bit per clock).
//
// Divides a 2*WIDTH-bit signed dividend by a WIDTH-bit signed divisor and
// returns a 2*WIDTH-bit quotient truncated toward zero plus a WIDTH-bit
// remainder carrying the dividend's sign (n = q*d + r, |r| < |d|).
// Latency from the accept edge to the edge raising dout_valid is always
// 2*WIDTH+2 cycles, including the divide-by-zero and overflow cases.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   din_valid / din_ready  operand handshake; ready only while idle
//   din_n [2W-1:0]         signed dividend
//   din_d [W-1:0]          signed divisor
//   dout_valid / dout_ready result handshake; outputs held until accepted
//   dout_q [2W-1:0]        signed quotient
//   dout_r [W-1:0]         signed remainder
//   dout_div0              divisor was zero (q = all ones, r = low dividend bits)
//   dout_ovf               most-negative / -1 (q = most-negative, r = 0)
module sdiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [2*WIDTH-1:0] din_n,
  input  logic [WIDTH-1:0]   din_d,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [2*WIDTH-1:0] dout_q,
  output logic [WIDTH-1:0]   dout_r,
  output logic               dout_div0,
  output logic               dout_ovf
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(W2);

  typedef enum logic [2:0] {S_IDLE, S_ABS, S_DIV, S_SIGN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   n_q, n_d;          // captured dividend (sign + div0 remainder)
  logic [WIDTH-1:0] d_q, d_d;         // captured divisor (sign)
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;
  logic [W2-1:0]   work_q, work_d;    // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder magnitude
  logic [WIDTH:0]  dmag_q, dmag_d;    // divisor magnitude, one extra bit for 2^(W-1)
  logic [W2-1:0]   out_quo_q, out_quo_d;
  logic [WIDTH-1:0] out_rem_q, out_rem_d;
  logic            out_div0_q, out_div0_d;
  logic            out_ovf_q, out_ovf_d;
  logic            out_valid_q, out_valid_d;

  logic [W2-1:0]   n_mag;
  logic [WIDTH:0]  d_ext, d_mag;
  logic [WIDTH:0]  shifted;
  logic [W2-1:0]   quo_signed;
  logic [WIDTH-1:0] rem_signed;

  assign din_ready  = (state_q == S_IDLE);
  assign dout_valid = out_valid_q;
  assign dout_q     = out_quo_q;
  assign dout_r     = out_rem_q;
  assign dout_div0  = out_div0_q;
  assign dout_ovf   = out_ovf_q;

  always_comb begin
    // NOTE: every variable written here is defaulted first, so no branch can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    d_d         = d_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
    work_d      = work_q;
    rem_d       = rem_q;
    dmag_d      = dmag_q;
    out_quo_d   = out_quo_q;
    out_rem_d   = out_rem_q;
    out_div0_d  = out_div0_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    // Unsigned magnitudes: |most-negative| = 2^(2W-1) still fits 2W unsigned
    // bits, and the divisor gets WIDTH+1 bits so |-2^(W-1)| is representable.
    n_mag = n_q[W2-1] ? (~n_q + W2'(1)) : n_q;
    d_ext = {d_q[WIDTH-1], d_q};
    d_mag = d_q[WIDTH-1] ? (~d_ext + (WIDTH+1)'(1)) : d_ext;

    shifted    = {rem_q, work_q[W2-1]};
    quo_signed = (n_q[W2-1] ^ d_q[WIDTH-1]) ? (~work_q + W2'(1)) : work_q;
    rem_signed = n_q[W2-1] ? (~rem_q + WIDTH'(1)) : rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (din_valid) begin
          n_d     = din_n;
          d_d     = din_d;
          div0_d  = (din_d == '0);
          ovf_d   = (din_n == {1'b1, {(W2-1){1'b0}}}) && (din_d == '1);
          state_d = S_ABS;
        end
      end
      S_ABS: begin
        work_d  = n_mag;
        dmag_d  = d_mag;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        // Restoring step: keep the trial difference only when it is non-negative.
        if (shifted >= dmag_q) begin
          rem_d  = WIDTH'(shifted - dmag_q);
          work_d = {work_q[W2-2:0], 1'b1};
        end else begin
          rem_d  = shifted[WIDTH-1:0];
          work_d = {work_q[W2-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W2 - 1)) state_d = S_SIGN;
      end
      S_SIGN: begin
        out_quo_d  = quo_signed;
        out_rem_d  = rem_signed;
        out_div0_d = div0_q;
        out_ovf_d  = ovf_q;
        if (div0_q) begin
          out_quo_d = '1;
          out_rem_d = n_q[WIDTH-1:0];
        end else if (ovf_q) begin
          out_quo_d = {1'b1, {(W2-1){1'b0}}};
          out_rem_d = '0;
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (dout_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments, so every flop samples the pre-edge value
  // of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      d_q         <= '0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      work_q      <= '0;
      rem_q       <= '0;
      dmag_q      <= '0;
      out_quo_q   <= '0;
      out_rem_q   <= '0;
      out_div0_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      d_q         <= d_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
      work_q      <= work_d;
      rem_q       <= rem_d;
      dmag_q      <= dmag_d;
      out_quo_q   <= out_quo_d;
      out_rem_q   <= out_rem_d;
      out_div0_q  <= out_div0_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_sdiv_iter.sv
// Testbench for sdiv_iter (WIDTH=8): directed vectors with literal expectations,
// plus a per-cycle compare against an arithmetic reference model.
module tb_sdiv_iter;

  localparam int W = 8;
  localparam int LAT = 2 * 2 * W / 2 + 2;  // 2W+2 = 18

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    logic        o;
  } res_t;

  logic        clk, rst_n;
  logic        din_valid, din_ready;
  logic [15:0] din_n;
  logic [7:0]  din_d;
  logic        dout_valid, dout_ready;
  logic [15:0] dout_q;
  logic [7:0]  dout_r;
  logic        dout_div0, dout_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sdiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .din_valid(din_valid), .din_ready(din_ready),
    .din_n(din_n), .din_d(din_d),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_q(dout_q), .dout_r(dout_r),
    .dout_div0(dout_div0), .dout_ovf(dout_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division truncates toward zero and % takes the
  // dividend's sign; the two flagged cases follow their override rules.
  function automatic res_t model(input logic signed [15:0] n, input logic signed [7:0] d);
    res_t r;
    int ni, di;
    ni = n;
    di = d;
    if (di == 0)                         r = {16'hFFFF, n[7:0], 1'b1, 1'b0};
    else if (ni == -32768 && di == -1)   r = {16'h8000, 8'h00, 1'b0, 1'b1};
    else                                 r = {16'(ni / di), 8'(ni % di), 1'b0, 1'b0};
    return r;
  endfunction

  function automatic res_t dut_out();
    return {dout_q, dout_r, dout_div0, dout_ovf};
  endfunction

  // Cycle-by-cycle compare: tracks busy/accept time and the expected and
  // last-delivered results, checking the handshake outputs and data each cycle.
  bit   busy = 0;
  int   acc_cyc = 0;
  res_t exp_res = '0;
  res_t last_res = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      busy     = 0;
      last_res = '0;
    end else begin
      bit exp_valid;
      exp_valid = busy && (cyc - acc_cyc >= LAT);
      check("cmp_din_ready", 32'(din_ready), 32'(!busy));
      check("cmp_dout_valid", 32'(dout_valid), 32'(exp_valid));
      if (exp_valid) check("cmp_result", 32'(dut_out()), 32'(exp_res));
      else           check("cmp_held", 32'(dut_out()), 32'(last_res));
      if (!busy && din_valid) begin
        busy    = 1;
        acc_cyc = cyc + 1;
        exp_res = model(din_n, din_d);
      end else if (exp_valid && dout_ready) begin
        busy     = 0;
        last_res = exp_res;
      end
    end
  end

  // One transaction. stall = cycles dout_ready stays low after dout_valid;
  // poke = drive new operands with din_valid during those stall cycles.
  task automatic do_op(input logic [15:0] n, input logic [7:0] d, input int stall,
                       input bit poke, output res_t got, output int lat);
    int t;
    @(posedge clk); #1;
    din_n = n; din_d = d; din_valid = 1'b1; dout_ready = 1'b0;
    t = 0;
    while (!din_ready && t < 50) begin @(posedge clk); #1; t++; end
    check("accept_ready", 32'(din_ready), 32'd1);
    @(posedge clk); #1;
    din_valid = 1'b0; din_n = 16'($urandom); din_d = 8'($urandom);
    t = 0;
    while (!dout_valid && t < 64) begin @(posedge clk); #1; t++; end
    check("result_seen", 32'(dout_valid), 32'd1);
    lat = t;
    got = dut_out();
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        din_valid = 1'b1; din_n = 16'($urandom); din_d = 8'($urandom);
        check("stall_din_ready", 32'(din_ready), 32'd0);
        check("stall_stable", 32'(dut_out()), 32'(got));
      end
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    check("valid_drop", 32'(dout_valid), 32'd0);
    check("ready_back", 32'(din_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d;
    res_t        e;
  } vec_t;

  vec_t vecs[8];

  initial begin
    res_t got;
    int   lat;
    din_valid = 0; din_n = '0; din_d = '0; dout_ready = 0;
    rst_n = 0;
    #12;
    check("rst_din_ready", 32'(din_ready), 32'd1);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_outputs", 32'(dut_out()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // Pin the reference model with hand-computed values.
    check("pin_100_7", 32'(model(16'sd100, 8'sd7)), 32'({16'h000E, 8'h02, 1'b0, 1'b0}));
    check("pin_m100_7", 32'(model(-16'sd100, 8'sd7)), 32'({16'hFFF2, 8'hFE, 1'b0, 1'b0}));
    check("pin_ovf", 32'(model(16'h8000, 8'hFF)), 32'({16'h8000, 8'h00, 1'b0, 1'b1}));
    check("pin_div0", 32'(model(16'sd5, 8'sd0)), 32'({16'hFFFF, 8'h05, 1'b1, 1'b0}));

    vecs[0] = '{16'd100,   8'd7,    {16'h000E, 8'h02, 1'b0, 1'b0}};
    vecs[1] = '{16'hFF9C,  8'd7,    {16'hFFF2, 8'hFE, 1'b0, 1'b0}};
    vecs[2] = '{16'd100,   8'hF9,   {16'hFFF2, 8'h02, 1'b0, 1'b0}};
    vecs[3] = '{16'hFF9C,  8'hF9,   {16'h000E, 8'hFE, 1'b0, 1'b0}};
    vecs[4] = '{16'h8000,  8'hFF,   {16'h8000, 8'h00, 1'b0, 1'b1}};
    vecs[5] = '{16'h8000,  8'h80,   {16'h0100, 8'h00, 1'b0, 1'b0}};
    vecs[6] = '{16'h7FFF,  8'h80,   {16'hFF01, 8'h7F, 1'b0, 1'b0}};
    vecs[7] = '{16'd5,     8'd0,    {16'hFFFF, 8'h05, 1'b1, 1'b0}};
    foreach (vecs[i]) begin
      do_op(vecs[i].n, vecs[i].d, 0, 0, got, lat);
      check($sformatf("vec%0d_result", i), 32'(got), 32'(vecs[i].e));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
    end

    // Backpressure: hold the result 10 cycles while new operands are offered.
    do_op(16'd1234, 8'd10, 10, 1, got, lat);
    check("bp_result", 32'(got), 32'({16'd123, 8'd4, 1'b0, 1'b0}));

    // Reset in the middle of the iteration.
    @(posedge clk); #1;
    din_n = 16'd1234; din_d = 8'd5; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_valid", 32'(dout_valid), 32'd0);
    check("midrst_outputs", 32'(dut_out()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    check("midrst_din_ready", 32'(din_ready), 32'd1);
    do_op(16'd1000, 8'hFD, 0, 0, got, lat);
    check("after_rst_result", 32'(got), 32'({16'hFEB3, 8'h01, 1'b0, 1'b0}));
    check("after_rst_latency", 32'(lat), 32'(LAT));

    // Random operands with random result stalls; corner operands mixed in.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] rn;
      logic [7:0]  rd;
      rn = 16'($urandom);
      rd = 8'($urandom);
      case ($urandom_range(0, 15))
        0: rd = 8'h00;
        1: rd = 8'hFF;
        2: rd = 8'h80;
        3: rn = 16'h8000;
        4: rn = 16'h7FFF;
        default: ;
      endcase
      do_op(rn, rd, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 0, got, lat);
      check("rnd_latency", 32'(lat), 32'(LAT));
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
